// File: rtl/gendata_pkg.sv
// rtl/gendata_pkg.sv - shared FSM encoding and PRBS-15 next-state function
package gendata_pkg;

    localparam int PRBS_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [PRBS_W-1:0] prbs15_step(input logic [PRBS_W-1:0] s);
        logic [PRBS_W-1:0] n;
        n[14:4] = s[10:0] ^ s[12:2];
        n[3]    = s[1]  ^ s[13] ^ s[14];
        n[2]    = s[0]  ^ s[12] ^ s[13];
        n[1]    = s[11] ^ s[12] ^ s[13] ^ s[14];
        n[0]    = s[10] ^ s[11] ^ s[12] ^ s[13];
        return n;
    endfunction

endpackage

// File: rtl/prbs15_wordmap.sv
// rtl/prbs15_wordmap.sv - replicate PRBS-15 state across a DATABIT word, with even parity
module prbs15_wordmap
    import gendata_pkg::*;
#(
    parameter int DATABIT = 32
) (
    input  logic [PRBS_W-1:0]  state,
    output logic [DATABIT-1:0] word,
    output logic               parity
);

    for (genvar k = 0; k < DATABIT; k++) begin : g_map
        assign word[k] = state[k % PRBS_W];
    end

    assign parity = ^word;

endmodule

// File: rtl/gendata.sv
// rtl/gendata.sv - PRBS-15 test-data generator with rate/burst control and error injection
module gendata
    import gendata_pkg::*;
#(
    parameter int               DATABIT  = 32,
    parameter logic [PRBS_W-1:0] PRBS_INI = 15'h0EE0
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         gap,
    input  logic [15:0]        burstlen,
    input  logic               injprbs,
    input  logic               injpar,
    output logic [DATABIT-1:0] odat,
    output logic               oval,
    output logic               opar,
    output logic               busy,
    output logic [31:0]        wcnt
);

    state_t              state;
    logic [PRBS_W-1:0]   s;
    logic                arm_prbs;
    logic                arm_par;
    logic [7:0]          gap_cnt;
    logic [15:0]         bcnt;
    logic [DATABIT-1:0]  held;
    logic [DATABIT-1:0]  map_word;
    logic                map_par;
    logic [DATABIT-1:0]  cur_word;
    logic [15:0]         bnext;
    logic                emit;
    logic                burst_done;

    prbs15_wordmap #(.DATABIT(DATABIT)) u_wordmap (
        .state  (s),
        .word   (map_word),
        .parity (map_par)
    );

    assign emit       = (state == ST_EMIT);
    assign bnext      = bcnt + 16'd1;
    assign burst_done = (burstlen != 16'd0) && (bnext == burstlen);

    always_comb begin
        cur_word    = map_word;
        cur_word[0] = map_word[0] ^ arm_prbs;
    end

    // The word is visible during the EMIT cycle itself; between emissions the last word is held.
    assign odat = emit ? cur_word : held;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= ST_IDLE;
            s        <= PRBS_INI;
            arm_prbs <= 1'b0;
            arm_par  <= 1'b0;
            gap_cnt  <= 8'd0;
            bcnt     <= 16'd0;
            held     <= '0;
            oval     <= 1'b0;
            opar     <= 1'b0;
            busy     <= 1'b0;
            wcnt     <= 32'd0;
        end else begin
            oval <= emit;
            if (emit) begin
                held <= cur_word;
                // flipping bit 0 flips parity, so a corrupted word keeps consistent parity
                opar <= map_par ^ arm_prbs ^ arm_par;
                s    <= arm_prbs ? PRBS_INI : prbs15_step(s);
                wcnt <= wcnt + 32'd1;
            end
            arm_prbs <= (arm_prbs & ~emit) | injprbs;
            arm_par  <= (arm_par  & ~emit) | injpar;

            if (stop) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                bcnt  <= 16'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_EMIT;
                            busy  <= 1'b1;
                        end
                    end
                    ST_EMIT: begin
                        if (burst_done) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            bcnt  <= 16'd0;
                        end else begin
                            bcnt <= bnext;
                            if (gap == 8'd0) begin
                                state <= ST_EMIT;
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= 8'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt >= gap) state <= ST_EMIT;
                        else                gap_cnt <= gap_cnt + 8'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gendata.sv
// tb/tb_gendata.sv - directed self-checking bench for gendata
module tb_gendata;

    localparam logic [14:0] INI = 15'h0EE0;

    logic        clk = 1'b0;
    logic        rst_;
    logic        start;
    logic        stop;
    logic [7:0]  gap;
    logic [15:0] burstlen;
    logic        injprbs;
    logic        injpar;
    logic [31:0] odat;
    logic        oval;
    logic        opar;
    logic        busy;
    logic [31:0] wcnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] last_dat = 32'd0;
    logic [31:0] cap_dat[$];
    logic        cap_par[$];
    int          cap_t[$];
    logic [14:0] ms;
    logic [31:0] base;

    gendata #(.DATABIT(32), .PRBS_INI(INI)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .start    (start),
        .stop     (stop),
        .gap      (gap),
        .burstlen (burstlen),
        .injprbs  (injprbs),
        .injpar   (injpar),
        .odat     (odat),
        .oval     (oval),
        .opar     (opar),
        .busy     (busy),
        .wcnt     (wcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Acts as the downstream monitor's input register: oval/opar qualify last cycle's odat.
    always @(negedge clk) begin
        if (oval) begin
            cap_dat.push_back(last_dat);
            cap_par.push_back(opar);
            cap_t.push_back(cyc);
        end
        last_dat = odat;
    end

    function automatic logic [14:0] m_step(input logic [14:0] x);
        logic [14:0] n;
        for (int i = 4; i < 15; i++) n[i] = x[i-4] ^ x[i-2];
        n[3] = x[1] ^ x[13] ^ x[14];
        n[2] = x[0] ^ x[12] ^ x[13];
        n[1] = x[11] ^ x[12] ^ x[13] ^ x[14];
        n[0] = x[10] ^ x[11] ^ x[12] ^ x[13];
        return n;
    endfunction

    function automatic logic [31:0] m_word(input logic [14:0] x);
        logic [31:0] w;
        for (int k = 0; k < 32; k++) w[k] = x[k % 15];
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_dat.delete();
        cap_par.delete();
        cap_t.delete();
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) tick();
        check("wait_idle", busy, 1'b0);
    endtask

    // Walk the captured words against the model; err_prbs/err_par give the injected word index or -1.
    task automatic check_stream(input string tag, input int n, input int err_prbs, input int err_par);
        logic [31:0] ew;
        logic        ep;
        check({tag, "_count"}, cap_dat.size(), n);
        for (int i = 0; i < n && i < cap_dat.size(); i++) begin
            ew = m_word(ms);
            if (i == err_prbs) ew[0] = ~ew[0];
            ep = (^ew) ^ (i == err_par);
            check($sformatf("%s_dat%0d", tag, i), cap_dat[i], ew);
            check($sformatf("%s_par%0d", tag, i), cap_par[i], ep);
            ms = (i == err_prbs) ? INI : m_step(ms);
        end
    endtask

    initial begin
        rst_ = 1'b0; start = 1'b0; stop = 1'b0; gap = 8'd0; burstlen = 16'd0;
        injprbs = 1'b0; injpar = 1'b0;
        ms = INI;
        repeat (3) tick();
        check("rst_odat", odat, 32'd0);
        check("rst_oval", oval, 1'b0);
        check("rst_opar", opar, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wcnt", wcnt, 32'd0);
        rst_ = 1'b1;
        tick();

        // single-word burst
        clear_cap();
        burstlen = 16'd1; gap = 8'd0;
        start = 1'b1; tick(); start = 1'b0;
        check("t2_odat", odat, 32'h07700EE0);
        check("t2_busy_hi", busy, 1'b1);
        check("t2_oval_lo", oval, 1'b0);
        tick();
        check("t2_oval", oval, 1'b1);
        check("t2_opar", opar, 1'b0);
        check("t2_busy_lo", busy, 1'b0);
        check("t2_wcnt", wcnt, 32'd1);
        check("t2_hold", odat, 32'h07700EE0);
        tick();
        check_stream("t2", 1, -1, -1);

        // continuous with gap=3, stopped after 10 words
        clear_cap();
        burstlen = 16'd0; gap = 8'd3; base = wcnt;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 100 && wcnt != base + 32'd10; i++) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (6) tick();
        check("t3_busy", busy, 1'b0);
        check("t3_wcnt", wcnt - base, 32'd10);
        if (cap_dat.size() > 0) begin
            check("t3_w0_const", cap_dat[0], 32'hAAC15582);
            check("t3_p0_const", cap_par[0], 1'b1);
        end
        for (int i = 1; i < cap_t.size(); i++)
            check($sformatf("t3_period%0d", i), cap_t[i] - cap_t[i-1], 4);
        check_stream("t3", 10, -1, -1);

        // gap=0 continuous run with one data corruption on the third word
        clear_cap();
        gap = 8'd0; burstlen = 16'd0; base = wcnt;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        injprbs = 1'b1; tick(); injprbs = 1'b0;
        for (int i = 0; i < 100 && wcnt < base + 32'd6; i++) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (3) tick();
        check("t4_wcnt", wcnt - base, 32'd7);
        for (int i = 1; i < cap_t.size(); i++)
            check($sformatf("t4_period%0d", i), cap_t[i] - cap_t[i-1], 1);
        if (cap_dat.size() > 3) check("t4_resync", cap_dat[3], 32'h07700EE0);
        check_stream("t4", 7, 2, -1);

        // parity injection armed during GAP
        clear_cap();
        gap = 8'd3; burstlen = 16'd4; base = wcnt;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        injpar = 1'b1; tick(); injpar = 1'b0;
        wait_idle(100);
        repeat (3) tick();
        check("t5_wcnt", wcnt - base, 32'd4);
        check_stream("t5", 4, -1, 1);

        // start+stop together is ignored; then start with both injections
        clear_cap();
        gap = 8'd0; burstlen = 16'd2; base = wcnt;
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        tick();
        check("t6_ignored_busy", busy, 1'b0);
        check("t6_ignored_wcnt", wcnt, base);
        start = 1'b1; injprbs = 1'b1; injpar = 1'b1; tick();
        start = 1'b0; injprbs = 1'b0; injpar = 1'b0;
        wait_idle(50);
        repeat (3) tick();
        if (cap_dat.size() > 1) check("t6_resync", cap_dat[1], 32'h07700EE0);
        check_stream("t6", 2, 0, 0);

        // asynchronous reset mid-burst
        clear_cap();
        gap = 8'd2; burstlen = 16'd50;
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        #2 rst_ = 1'b0;
        #1;
        check("t7_odat", odat, 32'd0);
        check("t7_oval", oval, 1'b0);
        check("t7_opar", opar, 1'b0);
        check("t7_busy", busy, 1'b0);
        check("t7_wcnt", wcnt, 32'd0);
        tick();
        rst_ = 1'b1;
        tick();
        clear_cap();
        ms = INI;
        gap = 8'd0; burstlen = 16'd1;
        start = 1'b1; tick(); start = 1'b0;
        check("t7_first", odat, 32'h07700EE0);
        wait_idle(10);
        repeat (2) tick();
        check("t7_wcnt1", wcnt, 32'd1);
        check_stream("t7", 1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
